// File: rtl/mem_pkg.sv
// Shared types, constants and helpers for the load/store unit and its lane logic.
// Optional build macro: LSU_MISALIGN_TRAP_EN (used by load_store_unit).
package mem_pkg;

    typedef logic [31:0] addr_t;
    typedef logic [31:0] data_t;

    localparam addr_t LEDR_ADDRESS = 32'h1000_0000;

    localparam logic [3:0] LANE_BYTE = 4'b0001;
    localparam logic [3:0] LANE_HALF = 4'b0011;
    localparam logic [3:0] LANE_WORD = 4'b1111;

    typedef enum logic [2:0] {
        Funct3Lb  = 3'b000,
        Funct3Lh  = 3'b001,
        Funct3Lw  = 3'b010,
        Funct3Lbu = 3'b100,
        Funct3Lhu = 3'b101
    } lsu_funct3_e;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWait,
        StResp
    } lsu_state_e;

    function automatic logic lsu_legal(input logic write, input logic [2:0] funct3);
        if (write) begin
            return (funct3[2] == 1'b0) && (funct3[1:0] != 2'b11);
        end
        return !((funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111));
    endfunction

    function automatic logic lsu_misaligned(input logic [2:0] funct3, input logic [1:0] off);
        case (funct3[1:0])
            2'b01:   return off[0];
            2'b10:   return off != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/load_store_unit_align.sv
// Combinational lane logic: store replication/strobes and load extraction/extension.
// Misaligned offsets are aligned down by only looking at the offset bits that matter.
module load_store_unit_align
    import mem_pkg::*;
(
    input  logic [1:0] st_size,
    input  logic [1:0] st_off,
    input  data_t      st_wdata,
    output data_t      st_data,
    output logic [3:0] st_we,
    input  logic [2:0] ld_funct3,
    input  logic [1:0] ld_off,
    input  data_t      ld_rdata,
    output data_t      ld_data
);

    always_comb begin
        st_data = st_wdata;
        st_we   = LANE_WORD;
        case (st_size)
            2'b00: begin
                st_data = {4{st_wdata[7:0]}};
                st_we   = LANE_BYTE << st_off;
            end
            2'b01: begin
                st_data = {2{st_wdata[15:0]}};
                st_we   = LANE_HALF << {st_off[1], 1'b0};
            end
            default: begin
                st_data = st_wdata;
                st_we   = LANE_WORD;
            end
        endcase
    end

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    always_comb begin
        case (ld_off)
            2'd0:    ld_byte = ld_rdata[7:0];
            2'd1:    ld_byte = ld_rdata[15:8];
            2'd2:    ld_byte = ld_rdata[23:16];
            default: ld_byte = ld_rdata[31:24];
        endcase
        ld_half = ld_off[1] ? ld_rdata[31:16] : ld_rdata[15:0];
    end

    always_comb begin
        ld_data = ld_rdata;
        case (ld_funct3)
            Funct3Lb:  ld_data = {{24{ld_byte[7]}}, ld_byte};
            Funct3Lbu: ld_data = {24'h0, ld_byte};
            Funct3Lh:  ld_data = {{16{ld_half[15]}}, ld_half};
            Funct3Lhu: ld_data = {16'h0, ld_half};
            default:   ld_data = ld_rdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store bus initiator: IDLE -> ISSUE -> WAIT (loads) -> RESP.
// Build macro LSU_MISALIGN_TRAP_EN turns misaligned accesses into error responses.
module load_store_unit
    import mem_pkg::*;
#(
    parameter int unsigned READ_LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [2:0]  req_funct3,
    input  addr_t       req_addr,
    input  data_t       req_wdata,
    output logic        rsp_valid,
    output data_t       rsp_rdata,
    output logic        rsp_error,
    output addr_t       mem_address,
    output data_t       mem_write_data,
    output logic [3:0]  mem_write_enable,
    input  data_t       mem_read_data
);

    lsu_state_e state_q;
    logic       write_q;
    logic [2:0] funct3_q;
    logic [1:0] off_q;
    logic [2:0] wait_cnt_q;

    data_t      st_data;
    logic [3:0] st_we;
    data_t      ld_data;
    logic       trap;

`ifdef LSU_MISALIGN_TRAP_EN
    assign trap = lsu_misaligned(req_funct3, req_addr[1:0]);
`else
    assign trap = 1'b0;
`endif

    assign req_ready = (state_q == StIdle);

    load_store_unit_align u_align (
        .st_size   (req_funct3[1:0]),
        .st_off    (req_addr[1:0]),
        .st_wdata  (req_wdata),
        .st_data   (st_data),
        .st_we     (st_we),
        .ld_funct3 (funct3_q),
        .ld_off    (off_q),
        .ld_rdata  (mem_read_data),
        .ld_data   (ld_data)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q          <= StIdle;
            write_q          <= 1'b0;
            funct3_q         <= 3'b000;
            off_q            <= 2'b00;
            wait_cnt_q       <= 3'd0;
            mem_address      <= '0;
            mem_write_data   <= '0;
            mem_write_enable <= 4'b0000;
            rsp_valid        <= 1'b0;
            rsp_error        <= 1'b0;
            rsp_rdata        <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (req_valid) begin
                        write_q  <= req_write;
                        funct3_q <= req_funct3;
                        off_q    <= req_addr[1:0];
                        if (!lsu_legal(req_write, req_funct3) || trap) begin
                            // Rejected request: no bus activity, straight to an error response.
                            state_q   <= StResp;
                            rsp_valid <= 1'b1;
                            rsp_error <= 1'b1;
                            rsp_rdata <= '0;
                        end else begin
                            state_q     <= StIssue;
                            mem_address <= {req_addr[31:2], 2'b00};
                            if (req_write) begin
                                mem_write_data   <= st_data;
                                mem_write_enable <= st_we;
                            end
                        end
                    end
                end
                StIssue: begin
                    mem_write_enable <= 4'b0000;
                    if (write_q) begin
                        state_q   <= StResp;
                        rsp_valid <= 1'b1;
                        rsp_error <= 1'b0;
                        rsp_rdata <= '0;
                    end else begin
                        state_q    <= StWait;
                        wait_cnt_q <= 3'(READ_LATENCY - 1);
                    end
                end
                StWait: begin
                    if (wait_cnt_q == 3'd0) begin
                        state_q   <= StResp;
                        rsp_valid <= 1'b1;
                        rsp_error <= 1'b0;
                        rsp_rdata <= ld_data;
                    end else begin
                        wait_cnt_q <= wait_cnt_q - 3'd1;
                    end
                end
                default: begin
                    state_q   <= StIdle;
                    rsp_valid <= 1'b0;
                    rsp_error <= 1'b0;
                    rsp_rdata <= '0;
                end
            endcase
        end
    end

endmodule
